// File: rtl/sm3_blk_ctrl_if.sv
// SM3 block sequencer bus bundle: register-file controls, message SRAM read port, core feed.
// Latency: none, wires only.
// Backpressure: none; the SRAM answers in a fixed cycle and the core always accepts words.
//
// Signals: ENABLE/SAR_ADDR/BSR (register file), MEM_REN/MEM_ADDR/MEM_RDATA (message SRAM),
//          CORE_INIT/CORE_WVALID/CORE_WDATA/CORE_DONE (compression core),
//          RES_LOAD/SET_STR/BUSY (status back to the register file).
// master = sequencer side, slave = environment side.
`timescale 1ns/1ps
interface sm3_blk_ctrl_if #(
    parameter int AW = 13
);
    logic          ENABLE;
    logic [AW-1:0] SAR_ADDR;
    logic [AW-1:0] BSR;
    logic          MEM_REN;
    logic [AW-1:0] MEM_ADDR;
    logic [31:0]   MEM_RDATA;
    logic          CORE_INIT;
    logic          CORE_WVALID;
    logic [31:0]   CORE_WDATA;
    logic          CORE_DONE;
    logic          RES_LOAD;
    logic          SET_STR;
    logic          BUSY;

    modport master (
        input  ENABLE, SAR_ADDR, BSR, MEM_RDATA, CORE_DONE,
        output MEM_REN, MEM_ADDR, CORE_INIT, CORE_WVALID, CORE_WDATA,
               RES_LOAD, SET_STR, BUSY
    );

    modport slave (
        output ENABLE, SAR_ADDR, BSR, MEM_RDATA, CORE_DONE,
        input  MEM_REN, MEM_ADDR, CORE_INIT, CORE_WVALID, CORE_WDATA,
               RES_LOAD, SET_STR, BUSY
    );
endinterface

// File: rtl/sm3_blk_ctrl.sv
// SM3 block sequencer: fetches BSR 16-word blocks from SRAM and streams them into the core.
// Latency: ENABLE rise -> CORE_INIT 1 cycle later; first read the cycle after; next block reads the cycle after CORE_DONE.
// Backpressure: none; the core accepts every word, and pacing between blocks comes only from CORE_DONE.
//
// Ports: AHB_HCLK (clock), AHB_HRESETN (synchronous active-low reset), bus (sm3_blk_ctrl_if.master).
// Optional build macro SM3_BLK_CTRL_BSWAP_EN: when defined, each SRAM word is byte-reversed
// before reaching the core (little-endian message storage). Timing is identical either way.
`timescale 1ns/1ps
module sm3_blk_ctrl #(
    parameter int AW  = 13,
    parameter int WPB = 16
) (
    input  logic           AHB_HCLK,
    input  logic           AHB_HRESETN,
    sm3_blk_ctrl_if.master bus
);
    localparam int WW = $clog2(WPB);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_FETCH = 3'd2,
        S_DRAIN = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        r_state;
    logic          r_en_d;
    logic [AW-1:0] r_blk_left;
    logic [AW-1:0] r_mem_addr;
    logic [WW-1:0] r_word;
    logic          r_mem_ren;
    logic          r_core_init;
    logic          r_wvalid;
    logic          r_res_load;
    logic          r_set_str;
    logic          r_busy;

    logic          w_start;
    logic [31:0]   w_rdata_fmt;

    assign w_start = bus.ENABLE & ~r_en_d;

`ifdef SM3_BLK_CTRL_BSWAP_EN
    assign w_rdata_fmt = {bus.MEM_RDATA[7:0],   bus.MEM_RDATA[15:8],
                          bus.MEM_RDATA[23:16], bus.MEM_RDATA[31:24]};
`else
    assign w_rdata_fmt = bus.MEM_RDATA;
`endif

    // r_mem_addr is a running pointer: blocks are contiguous in SRAM, so
    // base + blk*WPB + word is just one increment per read, wrapping at 2^AW.
    always_ff @(posedge AHB_HCLK) begin
        if (!AHB_HRESETN) begin
            r_state     <= S_IDLE;
            r_en_d      <= 1'b0;
            r_blk_left  <= '0;
            r_mem_addr  <= '0;
            r_word      <= '0;
            r_mem_ren   <= 1'b0;
            r_core_init <= 1'b0;
            r_wvalid    <= 1'b0;
            r_res_load  <= 1'b0;
            r_set_str   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_en_d      <= bus.ENABLE;
            // A read issued last cycle returns data now, even across an abort.
            r_wvalid    <= r_mem_ren;
            r_core_init <= 1'b0;
            r_res_load  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_blk_left <= bus.BSR;
                        r_mem_addr <= bus.SAR_ADDR;
                        r_word     <= '0;
                        if (bus.BSR == '0) begin
                            r_state   <= S_DONE;
                            r_set_str <= 1'b1;
                        end else begin
                            r_state     <= S_INIT;
                            r_core_init <= 1'b1;
                            r_busy      <= 1'b1;
                        end
                    end
                end
                S_INIT: begin
                    if (!bus.ENABLE) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state   <= S_FETCH;
                        r_mem_ren <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (!bus.ENABLE) begin
                        r_state   <= S_IDLE;
                        r_mem_ren <= 1'b0;
                        r_word    <= '0;
                        r_busy    <= 1'b0;
                    end else if (r_word == WW'(WPB - 1)) begin
                        r_state   <= S_DRAIN;
                        r_mem_ren <= 1'b0;
                        r_word    <= '0;
                    end else begin
                        r_word     <= r_word + WW'(1);
                        r_mem_addr <= r_mem_addr + AW'(1);
                    end
                end
                S_DRAIN: begin
                    if (!bus.ENABLE) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!bus.ENABLE) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (bus.CORE_DONE) begin
                        if (r_blk_left != AW'(1)) begin
                            r_blk_left <= r_blk_left - AW'(1);
                            r_mem_addr <= r_mem_addr + AW'(1);
                            r_mem_ren  <= 1'b1;
                            r_state    <= S_FETCH;
                        end else begin
                            r_res_load <= 1'b1;
                            r_set_str  <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!bus.ENABLE) begin
                        r_state   <= S_IDLE;
                        r_set_str <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_ren <= 1'b0;
                    r_busy    <= 1'b0;
                    r_set_str <= 1'b0;
                end
            endcase
        end
    end

    assign bus.MEM_REN     = r_mem_ren;
    assign bus.MEM_ADDR    = r_mem_addr;
    assign bus.CORE_INIT   = r_core_init;
    assign bus.CORE_WVALID = r_wvalid;
    // Gated so the word bus reads zero whenever no word is being delivered.
    assign bus.CORE_WDATA  = r_wvalid ? w_rdata_fmt : 32'h0;
    assign bus.RES_LOAD    = r_res_load;
    assign bus.SET_STR     = r_set_str;
    assign bus.BUSY        = r_busy;

endmodule

// File: doc/sm3_blk_ctrl.md
Name: sm3_blk_ctrl

Overview:
Sequencer between the SM3 register file and the SM3 compression core.
- When software sets ENABLE, it fetches BSR consecutive 512-bit message blocks from message SRAM, starting at word address SAR_ADDR.
- It streams each block's 16 words into the core and waits for the core's completion pulse.
- After the last block it requests the result latch and raises SET_STR.

Parameters:
AW, 13, message SRAM word-address width; matches the SAR_ADDR and BSR width.
WPB, 16, 32-bit words per message block; fixed by SM3, so it must not be overridden.

Ports:
AHB_HCLK  input  1  clock; all state changes on its rising edge
AHB_HRESETN  input  1  synchronous active-low reset
ENABLE  input  1  run request (ENR bit); level-sensitive
SAR_ADDR  input  AW  start word address of the message
BSR  input  AW  number of 512-bit blocks to hash
MEM_REN  output  1  SRAM read strobe
MEM_ADDR  output  AW  SRAM word address
MEM_RDATA  input  32  SRAM read data; valid exactly 1 cycle after MEM_REN
CORE_INIT  output  1  1-cycle pulse before block 0; the core loads the SM3 IV
CORE_WVALID  output  1  message word valid; the core always accepts it
CORE_WDATA  output  32  message word
CORE_DONE  input  1  1-cycle pulse from the core when a block's compression finishes
RES_LOAD  output  1  1-cycle pulse; the register file captures TEMP_RES into the result registers
SET_STR  output  1  completion status level; feeds the STR register
BUSY  output  1  high in every state except IDLE and DONE

Behaviour:
- Reset: all state and outputs go to 0 and the FSM enters IDLE. This happens synchronously on any edge with AHB_HRESETN=0, including mid-operation; no SRAM reads or core writes are issued after that edge.
- Start: ENABLE is sampled with a 1-cycle delayed copy. A rising edge in IDLE latches SAR_ADDR into base and BSR into blk_left, and clears the word and block counters. Later changes to SAR_ADDR/BSR are ignored until the next start.
- BSR==0: the FSM goes IDLE -> DONE directly. No CORE_INIT, no reads, no RES_LOAD pulse.
- INIT: 1 cycle with CORE_INIT=1, then FETCH.
- FETCH:
  - MEM_REN=1 for exactly WPB consecutive cycles.
  - MEM_ADDR = base + blk*WPB + word, computed modulo 2^AW, so it wraps 8191 -> 0.
  - CORE_WVALID is MEM_REN delayed by 1 cycle, and CORE_WDATA = MEM_RDATA in that cycle.
  - After the 16th read issue, the FSM goes to DRAIN.
- DRAIN: 1 cycle while the last word is delivered, then WAIT.
- WAIT: hold until CORE_DONE=1.
  - If blk_left > 1: decrement blk_left, increment blk, go to FETCH. The next read issues the cycle after CORE_DONE.
  - If blk_left == 1: pulse RES_LOAD for 1 cycle and go to DONE.
- CORE_DONE outside WAIT is ignored.
- DONE: SET_STR=1 and held. When ENABLE is low, go to IDLE on the next edge and clear SET_STR in the same cycle.
- Abort: ENABLE=0 in INIT, FETCH, DRAIN or WAIT returns the FSM to IDLE on the next edge.
  - MEM_REN drops from that edge; a word already in flight is still delivered.
  - No RES_LOAD pulse and no SET_STR.
- ENABLE held high in IDLE without a rising edge (for example after an abort followed by re-assert) does not restart. A fresh 0->1 transition is required.
- Latency, 1 block: ENABLE rise edge -> INIT (1) -> FETCH (16) -> DRAIN (1) -> WAIT (core-dependent) -> RES_LOAD on the cycle after CORE_DONE.
- Block counter width is AW. BSR=8191 with SAR=0 wraps the addresses; this is legal and no error is flagged.

Optional Feature:
SM3_BLK_CTRL_BSWAP_EN:
- Defined: CORE_WDATA is MEM_RDATA byte-reversed ({[7:0],[15:8],[23:16],[31:24]}), so software stores the message little-endian.
- Undefined: CORE_WDATA = MEM_RDATA unchanged (big-endian message words, as SM3 specifies).
- The macro changes no timing.

Test Plan:
- Single block:
  - Stimulus: SAR=0x010, BSR=1, SRAM[0x010+i]=i, ENABLE 0->1, CORE_DONE driven 20 cycles after the last word.
  - Required: CORE_INIT pulse; MEM_ADDR 0x010..0x01F; CORE_WDATA 0..15 on 16 consecutive cycles; RES_LOAD 1 cycle after CORE_DONE; SET_STR=1, BUSY=0.
- Multi-block with wrap:
  - Stimulus: SAR=0x1FF8, BSR=3.
  - Required: addresses 0x1FF8..0x1FFF, 0x0000..0x0027 in order; exactly one CORE_INIT; exactly 3 block bursts; one RES_LOAD.
- BSR=0:
  - Stimulus: ENABLE rises.
  - Required: SET_STR=1 within 2 cycles; MEM_REN, CORE_INIT and RES_LOAD never asserted.
- Abort:
  - Stimulus: ENABLE drops during the 8th read of block 0 (SAR=0, BSR=2).
  - Required: MEM_REN=0 from the next edge; no RES_LOAD, SET_STR stays 0; a new 0->1 restarts from address 0 with CORE_INIT.
- Reset mid-WAIT:
  - Stimulus: AHB_HRESETN=0 for 1 cycle while waiting.
  - Required: all outputs 0 on the next edge; a later CORE_DONE is ignored.
- With SM3_BLK_CTRL_BSWAP_EN defined:
  - Stimulus: MEM_RDATA=0x61626380.
  - Required: CORE_WDATA=0x80636261. Without the macro: CORE_WDATA=0x61626380.
